// File: rtl/execute_mc.sv
// Execute stage: a single-cycle ALU path plus an iterative radix-2 multiply /
// unsigned divide unit. Both paths share one registered result and flag set
// behind a valid/ready handshake. Three states: IDLE accepts, BUSY iterates,
// DONE holds the result until the consumer takes it.

// Combinational ALU, ctrl = {funct7[5], funct3}:
// 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU,
// 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, others -> 0.
module execute_mc_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [3:0]            ctrl_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  z_o,
    output logic                  n_o,
    output logic                  c_o,
    output logic                  v_o
);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int M  = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] add_w;
    logic [DATA_WIDTH:0] sub_w;
    logic [SW-1:0]       shamt;

    // Carry of SUB is "no borrow", i.e. a >= b unsigned.
    assign add_w = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign shamt = b_i[SW-1:0];

    // Operation decode; c/v are only meaningful for ADD and SUB.
    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        v_o      = 1'b0;
        case (ctrl_i)
            4'b0000: begin
                result_o = add_w[M:0];
                c_o      = add_w[DATA_WIDTH];
                v_o      = (a_i[M] == b_i[M]) && (add_w[M] != a_i[M]);
            end
            4'b1000: begin
                result_o = sub_w[M:0];
                c_o      = sub_w[DATA_WIDTH];
                v_o      = (a_i[M] != b_i[M]) && (sub_w[M] != a_i[M]);
            end
            4'b0001: result_o = a_i << shamt;
            4'b0010: result_o = {{M{1'b0}}, $signed(a_i) < $signed(b_i)};
            4'b0011: result_o = {{M{1'b0}}, a_i < b_i};
            4'b0100: result_o = a_i ^ b_i;
            4'b0101: result_o = a_i >> shamt;
            4'b1101: result_o = $signed(a_i) >>> shamt;
            4'b0110: result_o = a_i | b_i;
            4'b0111: result_o = a_i & b_i;
            default: result_o = '0;
        endcase
    end

    assign z_o = (result_o == '0);
    assign n_o = result_o[M];
endmodule

module execute_mc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] reg_data1,
    input  logic [DATA_WIDTH-1:0] reg_data2,
    input  logic [DATA_WIDTH-1:0] imm_ext,
    input  logic                  ALUsrc,
    input  logic [4:0]            op_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  z_flag,
    output logic                  n_flag,
    output logic                  c_flag,
    output logic                  v_flag,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  opa_q, opa_d;   // multiplicand (MUL*) or divisor (DIV/REM)
    logic [W-1:0]  hi_q, hi_d;     // product high half / partial remainder
    logic [W-1:0]  lo_q, lo_d;     // multiplier -> product low / dividend -> quotient
    logic [1:0]    mop_q, mop_d;
    logic [W-1:0]  res_q, res_d;
    logic          z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic [W-1:0]  opb;
    logic          accept;
    logic [W-1:0]  alu_res;
    logic          alu_z, alu_n, alu_c, alu_v;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ge;
    logic [W-1:0]  step_hi, step_lo, m_res;

    assign opb    = ALUsrc ? imm_ext : reg_data2;
    assign accept = in_valid && in_ready && !flush;

    // ALU sees the live operands so its output can be captured on the accept edge.
    execute_mc_alu #(.DATA_WIDTH(W)) u_alu (
        .a_i      (reg_data1),
        .b_i      (opb),
        .ctrl_i   (op_sel[3:0]),
        .result_o (alu_res),
        .z_o      (alu_z),
        .n_o      (alu_n),
        .c_o      (alu_c),
        .v_o      (alu_v)
    );

    // One radix-2 step: shift-add multiply or restoring divide. For a zero
    // divisor the compare always succeeds, giving quotient all ones and the
    // dividend shifted back out as the remainder.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opa_q};
        div_ge    = (div_shift >= {1'b0, opa_q});
        if (mop_q[1]) begin
            step_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            step_lo = {lo_q[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end
        // MUL/DIVU take the low register, MULHU/REMU the high one.
        m_res = mop_q[0] ? step_hi : step_lo;
    end

    // Next-state and datapath update; flush overrides everything and leaves
    // the visible result untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mop_d   = mop_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_sel[4]) begin
                        state_d = S_BUSY;
                        cnt_d   = CW'(W);
                        mop_d   = op_sel[1:0];
                        hi_d    = '0;
                        opa_d   = op_sel[1] ? opb : reg_data1;
                        lo_d    = op_sel[1] ? reg_data1 : opb;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        z_d     = alu_z;
                        n_d     = alu_n;
                        c_d     = alu_c;
                        v_d     = alu_v;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    res_d   = m_res;
                    z_d     = (m_res == '0);
                    n_d     = m_res[W-1];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
            z_d     = z_q;
            n_d     = n_q;
            c_d     = c_q;
            v_d     = v_q;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mop_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mop_q   <= mop_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q == S_BUSY);
    assign out_valid  = (state_q == S_DONE);
    assign alu_result = res_q;
    assign z_flag     = z_q;
    assign n_flag     = n_q;
    assign c_flag     = c_q;
    assign v_flag     = v_q;
endmodule

// File: tb/tb_execute_mc.sv
// Scoreboard bench for execute_mc (DATA_WIDTH = 32): expected results come
// from a behavioural model and are queued when an op is issued, then popped
// and compared when out_valid appears.
module tb_execute_mc;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;   // {z, n, c, v}
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        src;
        logic [4:0]  op;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        ALUsrc = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] reg_data1 = '0;
    logic [31:0] reg_data2 = '0;
    logic [31:0] imm_ext = '0;
    logic [4:0]  op_sel = '0;
    logic        in_ready, out_valid, busy;
    logic        z_flag, n_flag, c_flag, v_flag;
    logic [31:0] alu_result;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [31:0] last_res = '0;

    execute_mc #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reg_data1  (reg_data1),
        .reg_data2  (reg_data2),
        .imm_ext    (imm_ext),
        .ALUsrc     (ALUsrc),
        .op_sel     (op_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .c_flag     (c_flag),
        .v_flag     (v_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour written from the arithmetic definitions.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] r;
        logic        c, v;
        longint      s;
        r = '0; c = 1'b0; v = 1'b0;
        e.lat = 8'd1;
        if (op[4]) begin
            e.lat = 8'd33;
            p = {32'd0, a} * {32'd0, b};
            case (op[1:0])
                2'd0: r = p[31:0];
                2'd1: r = p[63:32];
                2'd2: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (op[3:0])
                4'h0: begin
                    r = a + b;
                    c = (r < a);
                    s = longint'($signed(a)) + longint'($signed(b));
                    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                4'h8: begin
                    r = a - b;
                    c = (a >= b);
                    s = longint'($signed(a)) - longint'($signed(b));
                    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                4'h1: r = a << b[4:0];
                4'h2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'h3: r = (a < b) ? 32'd1 : 32'd0;
                4'h4: r = a ^ b;
                4'h5: r = a >> b[4:0];
                4'hD: r = $unsigned($signed(a) >>> b[4:0]);
                4'h6: r = a | b;
                4'h7: r = a & b;
                default: r = '0;
            endcase
        end
        e.res   = r;
        e.flags = {(r == 32'd0), r[31], c, v};
        return e;
    endfunction

    // Issue one op from IDLE at a falling edge; returns at the falling edge
    // after the accepting rising edge.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic src, input logic [4:0] op);
        reg_data1 = a;
        reg_data2 = b;
        imm_ext   = imm;
        ALUsrc    = src;
        op_sel    = op;
        in_valid  = 1'b1;
        sb_q.push_back(model(a, src ? imm : b, op));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, counting cycles from the accept edge.
    // With scramble set, inputs churn while the op runs.
    task automatic wait_out(input bit scramble, output int lat, output bit timeout);
        lat = 1;
        timeout = 1'b0;
        while (out_valid !== 1'b1) begin
            if (lat >= 100) begin
                timeout = 1'b1;
                break;
            end
            if (scramble) begin
                reg_data1 = $urandom;
                reg_data2 = $urandom;
                imm_ext   = $urandom;
                ALUsrc    = 1'($urandom_range(0, 1));
                op_sel    = 5'($urandom);
                in_valid  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake out_valid=%b in_ready=%b exp out_valid=0 in_ready=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, alu_result, z_flag, n_flag, c_flag, v_flag} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b res=%h flags=%b exp all 0",
                     out_valid, busy, alu_result, {z_flag, n_flag, c_flag, v_flag});
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_alu();
        vec_t tv[$];
        exp_t e;
        int   lat;
        bit   to;
        tv = '{
            '{32'd5,         32'd7,  1'b1, 5'h00},   // ADD via immediate: 12
            '{32'd3,         32'd5,  1'b0, 5'h08},   // SUB: negative, borrow
            '{32'h7FFF_FFFF, 32'd1,  1'b0, 5'h00},   // ADD signed overflow
            '{32'hFFFF_FFFF, 32'd1,  1'b1, 5'h00},   // ADD wraps to zero, carry
            '{32'h8000_0000, 32'd4,  1'b0, 5'h0D},   // SRA
            '{32'h8000_0000, 32'd4,  1'b0, 5'h05},   // SRL
            '{32'd1,         32'd31, 1'b1, 5'h01},   // SLL
            '{32'hFFFF_FFFF, 32'd1,  1'b0, 5'h02},   // SLT signed
            '{32'hFFFF_FFFF, 32'd1,  1'b0, 5'h03},   // SLTU
            '{32'h0000_00F0, 32'h3C, 1'b0, 5'h07},   // AND
            '{32'h0000_00F0, 32'h3C, 1'b0, 5'h06},   // OR
            '{32'h0000_00F0, 32'hF0, 1'b0, 5'h04}    // XOR to zero
        };
        foreach (tv[i]) begin
            drive_op(tv[i].a, tv[i].src ? ~tv[i].b : tv[i].b, tv[i].src ? tv[i].b : ~tv[i].b, tv[i].src, tv[i].op);
            wait_out(1'b0, lat, to);
            e = sb_q.pop_front();
            $display("txn alu op=%h a=%h b=%h res=%h flags=%b lat=%0d", tv[i].op, tv[i].a, tv[i].b, alu_result,
                     {z_flag, n_flag, c_flag, v_flag}, lat);
            checks++;
            if (to || alu_result !== e.res) begin
                errors++;
                $display("FAIL alu_result[%0d] got=%h exp=%h timeout=%0d", i, alu_result, e.res, to);
            end
            checks++;
            if ({z_flag, n_flag, c_flag, v_flag} !== e.flags) begin
                errors++;
                $display("FAIL alu_flags[%0d] got=%b exp=%b", i, {z_flag, n_flag, c_flag, v_flag}, e.flags);
            end
            checks++;
            if (lat != int'(e.lat)) begin
                errors++;
                $display("FAIL alu_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            if (i == 0) begin
                checks++;
                if (alu_result !== 32'd12 || z_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_add_5_7 got=%h z=%b exp=0000000c z=0", alu_result, z_flag);
                end
            end
            last_res = e.res;
            consume("alu");
        end
    endtask

    task automatic test_mop();
        vec_t tv[$];
        exp_t e;
        int   lat;
        bit   to;
        tv = '{
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'h11},   // MULHU -> FFFFFFFE
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'h10},   // MUL   -> 1
            '{32'd100,       32'd7,         1'b0, 5'h12},   // DIVU  -> 14
            '{32'd100,       32'd7,         1'b1, 5'h1F},   // REMU  -> 2 ([3:2] set)
            '{32'h0000_1234, 32'd0,         1'b0, 5'h12},   // DIVU by zero -> all ones
            '{32'h0000_1234, 32'd0,         1'b0, 5'h13},   // REMU by zero -> A
            '{32'd0,         32'd12345,     1'b0, 5'h10}    // MUL zero -> z
        };
        foreach (tv[i]) begin
            drive_op(tv[i].a, tv[i].src ? ~tv[i].b : tv[i].b, tv[i].src ? tv[i].b : ~tv[i].b, tv[i].src, tv[i].op);
            wait_out(1'b1, lat, to);
            e = sb_q.pop_front();
            $display("txn mop op=%h a=%h b=%h res=%h flags=%b lat=%0d", tv[i].op, tv[i].a, tv[i].b, alu_result,
                     {z_flag, n_flag, c_flag, v_flag}, lat);
            checks++;
            if (to || alu_result !== e.res) begin
                errors++;
                $display("FAIL mop_result[%0d] got=%h exp=%h timeout=%0d", i, alu_result, e.res, to);
            end
            checks++;
            if ({z_flag, n_flag, c_flag, v_flag} !== e.flags) begin
                errors++;
                $display("FAIL mop_flags[%0d] got=%b exp=%b", i, {z_flag, n_flag, c_flag, v_flag}, e.flags);
            end
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL mop_latency[%0d] got=%0d exp=33", i, lat);
            end
            last_res = e.res;
            consume("mop");
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        bit   to;
        bit   bad;
        drive_op(32'd123, 32'd456, 32'd0, 1'b0, 5'h10);
        wait_out(1'b0, lat, to);
        e = sb_q.pop_front();
        $display("txn bp mul res=%h lat=%0d", alu_result, lat);
        checks++;
        if (to || alu_result !== e.res || lat != 33) begin
            errors++;
            $display("FAIL bp_result got=%h lat=%0d exp=%h lat=33", alu_result, lat, e.res);
        end
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            reg_data1 = $urandom;
            reg_data2 = $urandom;
            op_sel    = 5'($urandom);
            in_valid  = 1'b1;
            @(negedge clk);
            if (alu_result !== e.res || {z_flag, n_flag, c_flag, v_flag} !== e.flags ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad = 1'b1;
                $display("FAIL bp_hold cycle=%0d res=%h flags=%b valid=%b ready=%b exp res=%h flags=%b valid=1 ready=0",
                         k, alu_result, {z_flag, n_flag, c_flag, v_flag}, out_valid, in_ready, e.res, e.flags);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (bad) errors++;
        last_res = e.res;
        consume("bp");
    endtask

    task automatic test_flush();
        exp_t e;
        int   lat;
        bit   to;
        bit   seen;
        drive_op(32'hDEAD_BEEF, 32'd5, 32'd0, 1'b0, 5'h12);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_start got=%b exp=1", busy);
        end
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb_q.pop_front());
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle busy=%b valid=%b ready=%b exp 0 0 1", busy, out_valid, in_ready);
        end
        checks++;
        if (alu_result !== last_res) begin
            errors++;
            $display("FAIL flush_keep_result got=%h exp=%h", alu_result, last_res);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_valid got=1 exp=0");
        end
        $display("txn flush busy-cycle-10");
        drive_op(32'd9, 32'd3, 32'd0, 1'b0, 5'h12);
        wait_out(1'b1, lat, to);
        e = sb_q.pop_front();
        $display("txn divu 9/3 res=%h lat=%0d", alu_result, lat);
        checks++;
        if (to || alu_result !== e.res || lat != 33) begin
            errors++;
            $display("FAIL flush_next_divu got=%h lat=%0d exp=%h lat=33", alu_result, lat, e.res);
        end
        last_res = e.res;
        // Flush in DONE drops the result without a handshake.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== last_res) begin
            errors++;
            $display("FAIL flush_done valid=%b ready=%b res=%h exp 0 1 %h", out_valid, in_ready, alu_result, last_res);
        end
        // Flush beats an accept in IDLE.
        reg_data1 = 32'd1;
        reg_data2 = 32'd1;
        ALUsrc    = 1'b0;
        op_sel    = 5'h00;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== last_res) begin
            errors++;
            $display("FAIL flush_over_accept valid=%b res=%h exp 0 %h", out_valid, alu_result, last_res);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   lat;
        bit   to;
        drive_op(32'h0001_0003, 32'h0000_0777, 32'd0, 1'b0, 5'h10);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_front());
        last_res = '0;
        checks++;
        if ({out_valid, busy, alu_result, z_flag, n_flag, c_flag, v_flag} !== 38'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset valid=%b busy=%b res=%h flags=%b ready=%b exp all 0 ready=1",
                     out_valid, busy, alu_result, {z_flag, n_flag, c_flag, v_flag}, in_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_release_ready got=%b exp=1", in_ready);
        end
        drive_op(32'd6, 32'd7, 32'd0, 1'b0, 5'h10);
        wait_out(1'b1, lat, to);
        e = sb_q.pop_front();
        $display("txn mul 6*7 after reset res=%h lat=%0d", alu_result, lat);
        checks++;
        if (to || alu_result !== e.res || z_flag !== 1'b0 || lat != 33) begin
            errors++;
            $display("FAIL async_mul got=%h z=%b lat=%0d exp=%h z=0 lat=33", alu_result, z_flag, lat, e.res);
        end
        last_res = e.res;
        consume("async");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        drive_op(32'd10, 32'd20, 32'd0, 1'b0, 5'h00);
        wait_out(1'b0, lat, to);
        e = sb_q.pop_front();
        $display("txn b2b first res=%h lat=%0d", alu_result, lat);
        checks++;
        if (to || alu_result !== e.res) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", alu_result, e.res);
        end
        // New request offered on the handshake cycle: must not be taken.
        reg_data1 = 32'd3;
        reg_data2 = 32'd5;
        ALUsrc    = 1'b0;
        op_sel    = 5'h08;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bypass valid=%b ready=%b exp 0 1", out_valid, in_ready);
        end
        sb_q.push_back(model(32'd3, 32'd5, 5'h08));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(1'b0, lat, to);
        e = sb_q.pop_front();
        $display("txn b2b second res=%h lat=%0d", alu_result, lat);
        checks++;
        if (to || alu_result !== e.res || {z_flag, n_flag, c_flag, v_flag} !== e.flags || lat != 1) begin
            errors++;
            $display("FAIL b2b_second got=%h flags=%b lat=%0d exp=%h flags=%b lat=1",
                     alu_result, {z_flag, n_flag, c_flag, v_flag}, lat, e.res, e.flags);
        end
        last_res = e.res;
        consume("b2b");
    endtask

    task automatic test_random();
        logic [3:0]  codes[10];
        logic [31:0] a, b, imm;
        logic [4:0]  op;
        logic        src;
        exp_t        e;
        int          lat;
        bit          to;
        codes = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 7));
            src = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) op = {1'b1, 2'($urandom), 2'($urandom)};
            else                           op = {1'b0, codes[$urandom_range(0, 9)]};
            imm = src ? b : ~b;
            drive_op(a, src ? ~b : b, imm, src, op);
            wait_out(1'b1, lat, to);
            e = sb_q.pop_front();
            $display("txn rnd op=%h a=%h b=%h res=%h lat=%0d", op, a, b, alu_result, lat);
            checks++;
            if (to || alu_result !== e.res || {z_flag, n_flag, c_flag, v_flag} !== e.flags || lat != int'(e.lat)) begin
                errors++;
                $display("FAIL rnd[%0d] op=%h res=%h flags=%b lat=%0d exp=%h flags=%b lat=%0d", i, op, alu_result,
                         {z_flag, n_flag, c_flag, v_flag}, lat, e.res, e.flags, e.lat);
            end
            last_res = e.res;
            consume("rnd");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mop();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; SHALL support any even value 8..64.
REQ-002 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept.
- reg_data1  input  DATA_WIDTH  operand A.
- reg_data2  input  DATA_WIDTH  register operand B.
- imm_ext  input  DATA_WIDTH  immediate operand B.
- ALUsrc  input  1  1 selects imm_ext as B, else reg_data2.
- op_sel  input  5  [4]=0: ALU op, [3:0] drives existing alu ALUctrl; [4]=1: M-op, [1:0] 0=MUL, 1=MULHU, 2=DIVU, 3=REMU; [3:2] ignored.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- alu_result  output  DATA_WIDTH  registered result.
- z_flag, n_flag, c_flag, v_flag  output  1 each  registered flags.
- busy  output  1  high in BUSY state.

Function
REQ-003 Operand B SHALL be muxed by ALUsrc before capture; operands captured only on accept (in_valid & in_ready).
REQ-004 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-005 IDLE, accept of ALU op: next edge -> DONE, alu_result/flags = registered outputs of the existing alu instance on captured operands (latency 1).
REQ-006 IDLE, accept of M-op: next edge -> BUSY, iteration counter loaded with DATA_WIDTH.
REQ-007 BUSY: one radix-2 step per cycle (shift-add multiply, restoring unsigned divide); counter decrements; at counter 1 the next edge -> DONE with result; M-op latency SHALL be DATA_WIDTH+1 cycles accept-to-out_valid.
REQ-008 MUL result = low DATA_WIDTH bits of unsigned A*B; MULHU = high DATA_WIDTH bits of 2*DATA_WIDTH-bit product.
REQ-009 DIVU = floor(A/B), REMU = A mod B; B=0: DIVU = all ones, REMU = A, same latency, no exception.
REQ-010 M-op flags: z = (result==0), n = result[MSB], c = 0, v = 0.
REQ-011 DONE: out_valid = 1; alu_result and flags SHALL hold stable until out_ready; out_valid & out_ready -> IDLE next edge.
REQ-012 No accept in DONE on the handshake cycle (no bypass); back-to-back ops SHALL have >= 1 IDLE cycle between them.
REQ-013 flush SHALL force IDLE next edge from any state, dropping result, out_valid = 0; flush has priority over accept and out handshake; registered alu_result/flags unchanged.
REQ-014 in_valid with in_ready = 0 SHALL be ignored; inputs need not be held.
REQ-015 Inputs during BUSY SHALL not affect the running op.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, out_valid = 0, busy = 0, alu_result = 0, all flags = 0, counter = 0, internal operand/accumulator registers = 0.
REQ-017 Reset asserted mid-BUSY SHALL abandon the op; after release the first accepted op SHALL complete correctly.
REQ-018 in_ready SHALL be 1 in the first cycle after reset release.

Verification (DATA_WIDTH = 32)
REQ-019 ALU add: ALUsrc=1, A=5, imm=7, op_sel=ALU add -> out_valid 1 cycle after accept, result 12, z=0.
REQ-020 MULHU: A=0xFFFFFFFF, B=0xFFFFFFFF -> result 0xFFFFFFFE after 33 cycles; MUL same operands -> 0x00000001.
REQ-021 DIVU/REMU: A=100, B=7 -> 14 and 2; B=0, A=0x1234 -> DIVU 0xFFFFFFFF, REMU 0x1234, latency 33.
REQ-022 Backpressure: out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-023 flush at BUSY cycle 10 -> IDLE next edge, no out_valid; following DIVU 9/3 -> 3.
REQ-024 rst_n pulsed low mid-BUSY (asynchronous to clk) -> outputs 0 immediately; after release MUL 6*7 -> 42, z=0.
